// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for the UART TX arbiter.
// master = arbiter side, slave = requesters plus the shared transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 TX_VALID;
    logic [7:0]           TX_DATA;
    logic                 TX_READY;
    logic [NUM_REQ-1:0]   GRANT;
    logic                 BUSY;

    modport master (
        input  REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        output REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY
    );

    modport slave (
        output REQ_VALID, REQ_DATA, REQ_LAST, TX_READY,
        input  REQ_READY, TX_VALID, TX_DATA, GRANT, BUSY
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant lasts until packet end, a burst cap, or an idle timeout of the owner.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    uart_tx_arbiter_if.master  bus
);
    localparam int unsigned NR = NUM_REQ;
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = 12;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_rr_ptr;
    logic [BW-1:0]      r_burst;
    logic [TW-1:0]      r_quiet;

    logic               w_pick_found;
    logic [PW-1:0]      w_pick_idx;
    int unsigned        w_cand;
    logic               w_own_valid;
    logic               w_own_last;
    logic [7:0]         w_own_data;
    logic               w_beat;
    logic [BW-1:0]      w_burst_inc;
    logic [TW-1:0]      w_quiet_inc;
    logic               w_cap_hit;
    logic               w_timeout;
    logic               w_release;
    logic [PW-1:0]      w_next_ptr;

    // First valid requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_cand = (32'(r_rr_ptr) + k) % NR;
            if (!w_pick_found && bus.REQ_VALID[w_cand[PW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand[PW-1:0];
            end
        end
    end

    // Owner's stream selected by the one-hot grant; all zero while unowned.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (r_grant[k]) begin
                w_own_valid = bus.REQ_VALID[k];
                w_own_last  = bus.REQ_LAST[k];
                w_own_data  = bus.REQ_DATA[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_beat      = w_own_valid & bus.TX_READY;
        w_burst_inc = r_burst + 1'b1;
        w_quiet_inc = r_quiet + 1'b1;
        w_cap_hit   = (w_burst_inc == BW'(MAX_BURST));
        w_timeout   = !w_own_valid && (w_quiet_inc == TW'(IDLE_TIMEOUT));
        w_release   = (r_state == S_OWN) &&
                      ((w_beat && (w_own_last || w_cap_hit)) || w_timeout);
        w_next_ptr  = (r_owner == PW'(NR - 1)) ? '0 : r_owner + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_burst  <= '0;
            r_quiet  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_state <= S_OWN;
                        r_grant <= NUM_REQ'(1) << w_pick_idx;
                        r_busy  <= 1'b1;
                        r_owner <= w_pick_idx;
                        r_burst <= '0;
                        r_quiet <= '0;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        // LAST and burst cap on the same beat still release once.
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                        r_burst  <= '0;
                        r_quiet  <= '0;
                    end else begin
                        if (w_beat) begin
                            r_burst <= w_burst_inc;
                        end
                        r_quiet <= w_own_valid ? '0 : w_quiet_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_VALID  = w_own_valid;
    assign bus.TX_DATA   = w_own_data;
    assign bus.REQ_READY = r_grant & {NUM_REQ{bus.TX_READY}};
    assign bus.GRANT     = r_grant;
    assign bus.BUSY      = r_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the DUT and a
// transaction-level owner/pointer model predicts every output each cycle.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .MAX_BURST   (MB),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    // Each entry is {last, data}; the head is what the requester presents.
    logic [8:0] q [N][$];
    bit         en [N];
    bit [N-1:0] cur_vld;

    // Reference: who owns the bus, where the search starts, grant progress.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_quiet = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit last);
        q[r].push_back({last, d});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    task automatic step(input bit r, input bit txr);
        logic [N-1:0]   lst;
        logic [8*N-1:0] dat;
        logic [8:0]     head;
        logic [31:0]    exp_grant;
        bit             exp_txv;
        bit             rel;
        @(negedge clk);
        rst          = r;
        bus.TX_READY = txr;
        for (int i = 0; i < N; i++) begin
            cur_vld[i] = en[i] && (q[i].size() > 0);
            if (cur_vld[i]) begin
                dat[8*i +: 8] = q[i][0][7:0];
                lst[i]        = q[i][0][8];
            end else begin
                dat[8*i +: 8] = 8'($urandom);
                lst[i]        = 1'($urandom);
            end
        end
        bus.REQ_VALID = cur_vld;
        bus.REQ_DATA  = dat;
        bus.REQ_LAST  = lst;
        #1;
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        exp_txv   = (m_owner >= 0) && cur_vld[m_owner];
        chk("grant", 32'(bus.GRANT), exp_grant);
        chk("busy", 32'(bus.BUSY), 32'(m_owner >= 0));
        chk("tx_valid", 32'(bus.TX_VALID), 32'(exp_txv));
        chk("req_ready", 32'(bus.REQ_READY), txr ? exp_grant : 32'd0);
        if (exp_txv) chk("tx_data", 32'(bus.TX_DATA), 32'(q[m_owner][0][7:0]));

        if (r) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_quiet = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && cur_vld[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                    m_quiet = 0;
                end
            end
        end else begin
            rel = 1'b0;
            if (exp_txv && txr) begin
                head = q[m_owner].pop_front();
                m_beats++;
                if (head[8] || m_beats == MB) rel = 1'b1;
            end
            if (cur_vld[m_owner]) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet == TO) rel = 1'b1;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int left = budget;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        while (left > 0 && (pending() != 0 || m_owner >= 0)) begin
            step(1'b0, 1'b1);
            left--;
        end
        chk("drain_done", 32'(pending() + ((m_owner >= 0) ? 1 : 0)), 32'd0);
    endtask

    int  rr, len;
    bit  nolast;

    initial begin
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.REQ_LAST  = '0;
        bus.TX_READY  = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b1;

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Single 3-byte packet from requester 2
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1);

        // Round robin from pointer 0 with 1-byte packets everywhere
        step(1'b1, 1'b0);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) push(i, 8'(8'h80 + 8'(p * N + i)), 1'b1);
        drain(60);

        // Burst cap: 10 unterminated bytes on 1 competing with 3
        for (int b = 0; b < 10; b++) push(1, 8'(8'h10 + 8'(b)), 1'b0);
        push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b1);
        drain(200);

        // Backpressure on a single byte from 0
        push(0, 8'h55, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
        drain(20);

        // Owner 2 goes quiet after one byte; requester 0 waits for timeout
        push(2, 8'h77, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);
        push(0, 8'h99, 1'b1);
        drain(40);

        // Reset during beat 2 of a 5-byte packet; requester restarts it
        step(1'b1, 1'b0);
        for (int b = 0; b < 5; b++) push(1, 8'(8'hA0 + 8'(b)), b == 4);
        push(3, 8'h33, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        q[1].delete();
        for (int b = 0; b < 5; b++) push(1, 8'(8'hA0 + 8'(b)), b == 4);
        drain(60);

        // Random traffic, gating, backpressure and rare resets
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rr = $urandom_range(0, N - 1);
                if (q[rr].size() < 12) begin
                    len    = $urandom_range(1, 6);
                    nolast = ($urandom_range(0, 7) == 0);
                    for (int j = 0; j < len; j++)
                        push(rr, 8'($urandom), (j == len - 1) && !nolast);
                end
            end
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0);
        end
        drain(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant (1..255).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1024, cycles a granted requester may hold REQ_VALID low before the grant is revoked (1..4095).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CLK, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port REQ_VALID, input, NUM_REQ, bit i = requester i presents a byte.
REQ-008 SHALL have port REQ_DATA, input, 8*NUM_REQ, byte i in bits [8i+7:8i].
REQ-009 SHALL have port REQ_LAST, input, NUM_REQ, bit i = current byte ends requester i's packet.
REQ-010 SHALL have port REQ_READY, output, NUM_REQ, bit i = byte i accepted this cycle when REQ_VALID[i] is also high.
REQ-011 SHALL have port TX_VALID, output, 1, byte offered to the shared UART transmitter.
REQ-012 SHALL have port TX_DATA, output, 8, byte to transmit.
REQ-013 SHALL have port TX_READY, input, 1, transmitter accepts TX_DATA this cycle.
REQ-014 SHALL have port GRANT, output, NUM_REQ, registered one-hot owner; all-zero when unowned.
REQ-015 SHALL have port BUSY, output, 1, high while GRANT is non-zero.

Function
REQ-016 SHALL implement two states: IDLE (no owner) and OWN (one owner g).
REQ-017 SHALL, in IDLE with any REQ_VALID high, register GRANT to the first valid index found searching upward from rr_ptr with wrap, and enter OWN on the next edge; one-cycle arbitration latency.
REQ-018 SHALL drive TX_VALID=0, REQ_READY=0 while in IDLE; no byte passes in the arbitration cycle.
REQ-019 SHALL, in OWN, combinationally drive TX_VALID=REQ_VALID[g], TX_DATA=REQ_DATA byte g, REQ_READY[g]=TX_READY; REQ_READY of all other bits=0.
REQ-020 SHALL count a beat when TX_VALID and TX_READY are both high; burst counter width ceil(log2(MAX_BURST+1)), cleared on entering OWN.
REQ-021 SHALL release the grant (return to IDLE, GRANT=0) on the edge of a beat that has REQ_LAST[g]=1 or that is the MAX_BURST-th beat of the grant.
REQ-022 SHALL count consecutive OWN cycles with REQ_VALID[g]=0 (12-bit counter, cleared by any cycle with REQ_VALID[g]=1), and release the grant on the edge at which the count reaches IDLE_TIMEOUT.
REQ-023 SHALL, on every release, set rr_ptr to (g+1) mod NUM_REQ, so the releasing requester has lowest priority next arbitration.
REQ-024 SHALL ignore REQ_DATA/REQ_LAST of non-owners and REQ_LAST[g] when REQ_VALID[g]=0.
REQ-025 SHALL hold TX_DATA stable from the owner while TX_VALID=1 and TX_READY=0; stability of REQ_DATA under backpressure is the requester's obligation.
REQ-026 SHALL, when LAST and MAX_BURST coincide on one beat, release exactly once and advance rr_ptr once.
REQ-027 SHALL, when a requester raises REQ_VALID while another owns the bus, wait without data loss until the next IDLE arbitration.
REQ-028 SHALL, when only one requester is active, re-grant it after a one-cycle IDLE bubble following each release.

Reset
REQ-029 SHALL, while RESET=1 at an edge, set state IDLE, GRANT=0, BUSY=0, rr_ptr=0, burst and timeout counters=0; TX_VALID=0 and REQ_READY=0 during the following cycle.
REQ-030 SHALL, on RESET mid-packet, abandon the owner's packet without any further beat; the requester must restart its packet.

Verification
REQ-031 Single packet: REQ_VALID[2]=1, 3 bytes 0x41,0x42,0x43, LAST on 0x43, TX_READY=1 -> GRANT=0100 one cycle after valid, TX_DATA 0x41,0x42,0x43 on consecutive cycles, GRANT=0 after third beat, rr_ptr=3.
REQ-032 Round robin: all four valid continuously, 1-byte packets -> grant order 0,1,2,3,0, one IDLE cycle between grants.
REQ-033 Burst cap: MAX_BURST=4, requester 1 sends 10 bytes without LAST, requester 3 also valid -> 4 bytes from 1, then grant 3, then back to 1 to continue with byte 5.
REQ-034 Backpressure: owner 0 valid with 0x55, TX_READY low 5 cycles -> TX_VALID=1, TX_DATA=0x55 held, REQ_READY[0]=0 until TX_READY=1, exactly one beat counted.
REQ-035 Timeout: IDLE_TIMEOUT=8, owner 2 drops REQ_VALID after 1 byte -> GRANT=0 exactly 8 cycles later, requester 0 then granted if valid.
REQ-036 Reset mid-packet: RESET pulse during beat 2 of a 5-byte packet -> next cycle GRANT=0, TX_VALID=0, rr_ptr=0; lowest valid index granted after RESET deasserts.
